// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async_fifo read-side drain stage.
package async_fifo_pkg;

  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Number of words held for a given occupancy state.
  function automatic logic [1:0] occ_level(input occ_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/async_fifo_rd_stream_skid_buf2.sv
// Two-entry valid/ready skid buffer: push lands at the tail, pop removes the head.
module skid_buf2
  import async_fifo_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] dout_o,
  output occ_e             occ_o
);

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  always_ff @(posedge clk_i) begin
    // NOTE: the data entries are reset along with the state so the head reads 0 out of reset.
    if (rst_i) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (clr_i) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: if (push_i) begin
          occ_d  = OCC_ONE;
          head_d = din_i;
        end
        OCC_ONE: begin
          if (push_i && pop_i) begin
            head_d = din_i;
          end else if (push_i) begin
            occ_d  = OCC_TWO;
            tail_d = din_i;
          end else if (pop_i) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_TWO: if (pop_i) begin
          occ_d  = OCC_ONE;
          head_d = tail_q;
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_comb begin
    valid_o = (occ_q != OCC_EMPTY);
    dout_o  = head_q;
    occ_o   = occ_q;
  end

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Drains async_fifo in the read domain: issues r_en, absorbs the one-cycle read
// latency and re-presents the words as a valid/ready stream through a 2-entry skid buffer.
module async_fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             r_clk,
  input  logic             r_rst,
  input  logic             flush,
  output logic             fifo_r_en,
  input  logic [WIDTH-1:0] fifo_dat,
  input  logic             fifo_empty,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [CNT_W-1:0] m_count,
  output logic             busy
);

  occ_e             occ;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             m_fire;
  logic             land;
  logic [2:0]       committed;

  assign m_fire = m_valid && m_ready;

  // Slots still spoken for after this edge; a new read may only claim a free one.
  assign committed = 3'(occ_level(occ)) + 3'(inflight_q) - 3'(m_fire);
  assign fifo_r_en = !r_rst && !flush && !fifo_empty && (committed < 3'd2);

  // No read is issued on the flush cycle, so the edge after a flush never has a landing.
  assign land = inflight_q && !flush;

  always_comb begin
    inflight_d = fifo_r_en && !fifo_empty;
    count_d    = count_q;
    if (m_fire && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      inflight_q <= 1'b0;
      count_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
    end
  end

  skid_buf2 #(.WIDTH(WIDTH)) u_skid (
    .clk_i  (r_clk),
    .rst_i  (r_rst),
    .clr_i  (flush),
    .push_i (land),
    .pop_i  (m_fire),
    .din_i  (fifo_dat),
    .valid_o(m_valid),
    .dout_o (m_data),
    .occ_o  (occ)
  );

  assign m_count = count_q;
  assign busy    = (occ != OCC_EMPTY) || inflight_q;

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Bench for async_fifo_rd_stream: a queue-based FIFO model feeds the DUT and a
// scoreboard of words read-but-not-delivered predicts the stream on every cycle.
module tb_async_fifo_rd_stream;

  localparam int WIDTH = 5;
  localparam int DEPTH = 16;

  logic             r_clk = 1'b0;
  logic             r_rst = 1'b1;
  logic             flush = 1'b0;
  logic             m_ready = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_dat = '0;

  logic             fifo_r_en, m_valid, busy;
  logic [WIDTH-1:0] m_data;
  logic [15:0]      m_count;
  logic             fifo_r_en3, m_valid3, busy3;
  logic [WIDTH-1:0] m_data3;
  logic [2:0]       m_count3;

  async_fifo_rd_stream #(.WIDTH(WIDTH), .CNT_W(16)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .flush(flush), .fifo_r_en(fifo_r_en),
    .fifo_dat(fifo_dat), .fifo_empty(fifo_empty), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .m_count(m_count), .busy(busy)
  );

  // Narrow-counter copy fed the same inputs, used for the saturation checks.
  async_fifo_rd_stream #(.WIDTH(WIDTH), .CNT_W(3)) dut_w3 (
    .r_clk(r_clk), .r_rst(r_rst), .flush(flush), .fifo_r_en(fifo_r_en3),
    .fifo_dat(fifo_dat), .fifo_empty(fifo_empty), .m_valid(m_valid3),
    .m_data(m_data3), .m_ready(m_ready), .m_count(m_count3), .busy(busy3)
  );

  always #5 r_clk = ~r_clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               rc;
  } ent_t;

  logic [WIDTH-1:0] fq[$];
  ent_t             pend[$];
  int               delivered[$];
  int               fire_cyc[$];
  int cyc = 0, rd_cnt = 0, bad_ren = 0, cnt_m = 0, cnt3_m = 0;
  int n_checks = 0, n_pass = 0;
  bit s_ren = 0, s_empty = 1, s_mfire = 0, s_flush = 0, s_rst = 1;
  logic [WIDTH-1:0] s_mdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // FIFO model and scoreboard advance on the clock edge from values sampled mid-cycle.
  always @(posedge r_clk) begin : model
    ent_t             e;
    logic [WIDTH-1:0] w;
    cyc++;
    if (s_mfire && !s_rst) begin
      delivered.push_back(int'(s_mdata));
      fire_cyc.push_back(cyc);
      if (cnt_m < 65535) cnt_m++;
      if (cnt3_m < 7) cnt3_m++;
      if (!s_flush && pend.size() > 0) e = pend.pop_front();
    end
    if (s_rst) begin
      pend.delete();
      cnt_m  = 0;
      cnt3_m = 0;
    end else if (s_flush) begin
      pend.delete();
    end
    if (s_ren && s_empty) bad_ren++;
    if (s_ren && !s_empty && fq.size() > 0) begin
      w = fq.pop_front();
      fifo_dat <= w;
      rd_cnt++;
      if (!s_rst && !s_flush) pend.push_back('{w, cyc});
    end
    fifo_empty <= (fq.size() == 0);
  end

  // A word read at edge k is on the output from edge k+1 until accepted.
  always @(negedge r_clk) begin : compare
    bit ev, er;
    int fire;
    if (cyc > 0) begin
      ev = (pend.size() > 0) && (pend[0].rc < cyc);
      check("m_valid", m_valid, ev);
      check("m_valid_w3", m_valid3, ev);
      if (ev) check("m_data", m_data, pend[0].d);
      check("busy", busy, pend.size() != 0);
      check("m_count", m_count, cnt_m);
      check("m_count_w3", m_count3, cnt3_m);
      fire = (ev && m_ready) ? 1 : 0;
      er = !r_rst && !flush && !fifo_empty && ((pend.size() - fire) < 2);
      check("fifo_r_en", fifo_r_en, er);
      check("fifo_r_en_w3", fifo_r_en3, er);
    end
    s_ren   = fifo_r_en;
    s_empty = fifo_empty;
    s_mfire = m_valid && m_ready;
    s_mdata = m_data;
    s_flush = flush;
    s_rst   = r_rst;
  end

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic write_words(input int first, input int n);
    for (int i = 0; i < n; i++)
      if (fq.size() < DEPTH) fq.push_back(WIDTH'(first + i));
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((fq.size() != 0 || pend.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained"}, fq.size() + pend.size(), 0);
  endtask

  task automatic check_seq(input string name, input int first, input int n);
    check({name, "_len"}, delivered.size(), n);
    for (int i = 0; i < n; i++)
      if (i < delivered.size()) check({name, "_word"}, delivered[i], first + i);
  endtask

  task automatic pulse_reset();
    r_rst   = 1'b1;
    m_ready = 1'b0;
    tick();
    r_rst = 1'b0;
    delivered.delete();
    fire_cyc.delete();
    rd_cnt = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    // Reset values.
    @(posedge r_clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_count", m_count, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_r_en", fifo_r_en, 0);
    pulse_reset();

    // 1: full-rate drain of 7..22, with first-word latency pinned.
    m_ready = 1'b1;
    write_words(7, 16);
    tick();
    check("t1_ren_first", fifo_r_en, 1);
    check("t1_valid_c0", m_valid, 0);
    tick();
    check("t1_valid_c1", m_valid, 0);
    check("t1_busy_c1", busy, 1);
    check("t1_fifo_dat", fifo_dat, 7);
    tick();
    check("t1_valid_c2", m_valid, 1);
    check("t1_data_c2", m_data, 7);
    drain("t1", 100);
    check_seq("t1", 7, 16);
    check("t1_count", m_count, 16);
    check("t1_count_w3_sat", m_count3, 7);
    if (fire_cyc.size() == 16) check("t1_rate", fire_cyc[15] - fire_cyc[0], 15);

    // 2: long stall holds exactly two words, then releases in order.
    pulse_reset();
    write_words(7, 16);
    repeat (20) tick();
    check("t2_reads", rd_cnt, 2);
    check("t2_valid", m_valid, 1);
    check("t2_data", m_data, 7);
    check("t2_fifo_left", fq.size(), 14);
    m_ready = 1'b1;
    drain("t2", 100);
    check_seq("t2", 7, 16);

    // 3: overfilled write, alternating ready.
    pulse_reset();
    write_words(7, 21);
    check("t3_stored", fq.size(), 16);
    for (int i = 0; i < 300 && (fq.size() != 0 || pend.size() != 0); i++) begin
      m_ready = (i % 2 == 0);
      tick();
    end
    drain("t3", 20);
    check_seq("t3", 7, 16);
    check("t3_bad_ren", bad_ren, 0);

    // 4: flush with two words held, then with one held and one in flight.
    pulse_reset();
    write_words(7, 16);
    repeat (6) tick();
    check("t4_full_valid", m_valid, 1);
    check("t4_full_data", m_data, 7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_flush1_valid", m_valid, 0);
    check("t4_flush1_busy", busy, 0);
    check("t4_flush1_count", m_count, 0);
    repeat (4) tick();
    check("t4_head_after_flush", m_data, 9);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    flush   = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_flush2_valid", m_valid, 0);
    check("t4_flush2_count", m_count, 1);
    m_ready = 1'b1;
    drain("t4", 100);
    check("t4_len", delivered.size(), 12);
    if (delivered.size() == 12) begin
      check("t4_first", delivered[0], 9);
      for (int i = 1; i < 12; i++) check("t4_word", delivered[i], 11 + i);
    end
    check("t4_count", m_count, 12);

    // 5: reset mid-stream with one word held and one in flight.
    pulse_reset();
    m_ready = 1'b1;
    write_words(7, 16);
    repeat (6) tick();
    check("t5_pre_count", m_count, 3);
    check("t5_pre_data", m_data, 10);
    check("t5_pre_busy", busy, 1);
    r_rst   = 1'b1;
    m_ready = 1'b0;
    #1;
    check("t5_rst_ren", fifo_r_en, 0);
    tick();
    r_rst = 1'b0;
    check("t5_valid", m_valid, 0);
    check("t5_data", m_data, 0);
    check("t5_count", m_count, 0);
    check("t5_busy", busy, 0);
    delivered.delete();
    m_ready = 1'b1;
    drain("t5", 100);
    check_seq("t5", 12, 11);
    check("t5_final_count", m_count, 11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
